// File: rtl/l1_l2_request_arbiter.sv
// l1_l2_request_arbiter
//
// Purpose: arbitrates the instruction cache (client 0) and the data cache
// (client 1) onto the single shared L2 request port. A client keeps the grant
// for as long as it holds its valid high. The address, type and write data of
// the granted client are muxed to L2. Fulfilled and read data are returned to
// the granted client only. A lock counter bounds how long one client may hold
// the grant while the other one is waiting.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   ic_req_*          icache request (valid/type/address) and its response
//                     (fulfilled/rdata)
//   dc_req_*          dcache request (valid/type/address/wdata) and its
//                     response (fulfilled/rdata)
//   l2_req_*          request to L2 (valid/type/address/wdata) and the L2
//                     response (fulfilled/rdata)
//   protocol_error    sticky flag: L2 signalled fulfilled with no request
//                     outstanding

package l1_l2_arb_pkg;
   typedef enum logic [1:0] {
      LOAD       = 2'b00,
      STORE      = 2'b01,
      MO_UNKNOWN = 2'b11
   } memory_operation_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_GRANT_IC = 2'b01,
      ST_GRANT_DC = 2'b10
   } arb_state_e;
endpackage

module l1_l2_request_arbiter
   import l1_l2_arb_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int LOCK_MAX = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req_valid,
   input  memory_operation_e ic_req_type,
   input  logic [XLEN-1:0]   ic_req_address,
   output logic              ic_req_fulfilled,
   output logic [XLEN-1:0]   ic_req_rdata,
   input  logic              dc_req_valid,
   input  memory_operation_e dc_req_type,
   input  logic [XLEN-1:0]   dc_req_address,
   input  logic [XLEN-1:0]   dc_req_wdata,
   output logic              dc_req_fulfilled,
   output logic [XLEN-1:0]   dc_req_rdata,
   output logic              l2_req_valid,
   output memory_operation_e l2_req_type,
   output logic [XLEN-1:0]   l2_req_address,
   output logic [XLEN-1:0]   l2_req_wdata,
   input  logic              l2_req_fulfilled,
   input  logic [XLEN-1:0]   l2_req_rdata,
   output logic              protocol_error
);

   // The counter has to be able to hold LOCK_MAX itself, because it saturates there.
   localparam int CW = (LOCK_MAX < 1) ? 1 : $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LOCK_LIMIT = CW'(LOCK_MAX);

   arb_state_e    state, next_state;
   logic          last_grant;    // 1 = dcache held the most recent grant
   logic [CW-1:0] lock_cnt;
   logic          other_valid;   // the client that is not granted is waiting
   logic          lock_expired;
   logic          grant_entry;

   assign lock_expired = (LOCK_MAX != 0) && (lock_cnt == LOCK_LIMIT);
   assign grant_entry  = (next_state != state) && (next_state != ST_IDLE);

   always_comb begin
      other_valid = 1'b0;
      if (state == ST_GRANT_IC) other_valid = dc_req_valid;
      if (state == ST_GRANT_DC) other_valid = ic_req_valid;
   end

   // State register
   // NOTE: sequential state uses non-blocking assignments only, so every
   // flop samples the values that were present before the clock edge.
   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= next_state;
   end

   // Grant history, lock counter and sticky error flag
   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant     <= 1'b1;   // dcache, so the icache wins the first tie
         lock_cnt       <= '0;
         protocol_error <= 1'b0;
      end else begin
         if (grant_entry) begin
            last_grant <= (next_state == ST_GRANT_DC);
            lock_cnt   <= '0;
         end else if (other_valid && (lock_cnt != LOCK_LIMIT)) begin
            lock_cnt <= lock_cnt + CW'(1);
         end
         if (l2_req_fulfilled && !l2_req_valid) protocol_error <= 1'b1;
      end
   end

   // Next-state logic. A forced rotation happens only on a fulfilled beat, so
   // a beat that is in flight is never abandoned.
   // NOTE: next_state gets a default before the case statement, so no path
   // leaves it unassigned and no latch is inferred.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if (ic_req_valid && (!dc_req_valid || last_grant)) next_state = ST_GRANT_IC;
            else if (dc_req_valid)                             next_state = ST_GRANT_DC;
         end
         ST_GRANT_IC: begin
            if (!ic_req_valid)
               next_state = dc_req_valid ? ST_GRANT_DC : ST_IDLE;
            else if (lock_expired && l2_req_fulfilled && dc_req_valid)
               next_state = ST_GRANT_DC;
         end
         ST_GRANT_DC: begin
            if (!dc_req_valid)
               next_state = ic_req_valid ? ST_GRANT_IC : ST_IDLE;
            else if (lock_expired && l2_req_fulfilled && ic_req_valid)
               next_state = ST_GRANT_IC;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   // Output logic. While reset is asserted every output is held at its idle
   // value, so no beat can reach a client during the reset cycle. A fulfilled
   // pulse with no request outstanding is never forwarded to a client.
   always_comb begin
      l2_req_valid     = 1'b0;
      l2_req_type      = LOAD;
      l2_req_address   = '0;
      l2_req_wdata     = '0;
      ic_req_fulfilled = 1'b0;
      ic_req_rdata     = '0;
      dc_req_fulfilled = 1'b0;
      dc_req_rdata     = '0;
      if (!reset) begin
         case (state)
            ST_IDLE: ;
            ST_GRANT_IC: begin
               l2_req_valid     = ic_req_valid;
               l2_req_type      = ic_req_type;
               l2_req_address   = ic_req_address;
               ic_req_fulfilled = l2_req_fulfilled & ic_req_valid;
               ic_req_rdata     = l2_req_rdata;
            end
            ST_GRANT_DC: begin
               l2_req_valid     = dc_req_valid;
               l2_req_type      = dc_req_type;
               l2_req_address   = dc_req_address;
               l2_req_wdata     = dc_req_wdata;
               dc_req_fulfilled = l2_req_fulfilled & dc_req_valid;
               dc_req_rdata     = l2_req_rdata;
            end
            default: begin
               l2_req_valid     = 1'bx;
               l2_req_type      = MO_UNKNOWN;
               l2_req_address   = 'x;
               l2_req_wdata     = 'x;
               ic_req_fulfilled = 1'bx;
               ic_req_rdata     = 'x;
               dc_req_fulfilled = 1'bx;
               dc_req_rdata     = 'x;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_l1_l2_request_arbiter.sv
// tb_l1_l2_request_arbiter
//
// Purpose: directed self-checking bench for l1_l2_request_arbiter, built with
// LOCK_MAX = 4 so that forced rotation can be exercised. Inputs change 1 ns
// after each rising edge. Outputs are sampled 2 ns after the inputs change.
//
// Ports: none (top-level bench).

module tb_l1_l2_request_arbiter;
   import l1_l2_arb_pkg::*;

   localparam int XLEN = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              ic_req_valid;
   memory_operation_e ic_req_type;
   logic [XLEN-1:0]   ic_req_address;
   logic              ic_req_fulfilled;
   logic [XLEN-1:0]   ic_req_rdata;
   logic              dc_req_valid;
   memory_operation_e dc_req_type;
   logic [XLEN-1:0]   dc_req_address;
   logic [XLEN-1:0]   dc_req_wdata;
   logic              dc_req_fulfilled;
   logic [XLEN-1:0]   dc_req_rdata;
   logic              l2_req_valid;
   memory_operation_e l2_req_type;
   logic [XLEN-1:0]   l2_req_address;
   logic [XLEN-1:0]   l2_req_wdata;
   logic              l2_req_fulfilled;
   logic [XLEN-1:0]   l2_req_rdata;
   logic              protocol_error;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   l1_l2_request_arbiter #(.XLEN(XLEN), .LOCK_MAX(4)) dut (
      .clk              (clk),
      .reset            (reset),
      .ic_req_valid     (ic_req_valid),
      .ic_req_type      (ic_req_type),
      .ic_req_address   (ic_req_address),
      .ic_req_fulfilled (ic_req_fulfilled),
      .ic_req_rdata     (ic_req_rdata),
      .dc_req_valid     (dc_req_valid),
      .dc_req_type      (dc_req_type),
      .dc_req_address   (dc_req_address),
      .dc_req_wdata     (dc_req_wdata),
      .dc_req_fulfilled (dc_req_fulfilled),
      .dc_req_rdata     (dc_req_rdata),
      .l2_req_valid     (l2_req_valid),
      .l2_req_type      (l2_req_type),
      .l2_req_address   (l2_req_address),
      .l2_req_wdata     (l2_req_wdata),
      .l2_req_fulfilled (l2_req_fulfilled),
      .l2_req_rdata     (l2_req_rdata),
      .protocol_error   (protocol_error)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance to 1 ns after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int icn, dcn, k;

      reset            = 1'b1;
      ic_req_valid     = 1'b0;
      ic_req_type      = LOAD;
      ic_req_address   = '0;
      dc_req_valid     = 1'b0;
      dc_req_type      = LOAD;
      dc_req_address   = '0;
      dc_req_wdata     = '0;
      l2_req_fulfilled = 1'b0;
      l2_req_rdata     = '0;

      // ---------------- reset state ----------------
      tick();
      #2;
      check("rst_l2_valid", 32'(l2_req_valid), 0);
      check("rst_l2_type", 32'(l2_req_type), 32'(LOAD));
      check("rst_l2_addr", l2_req_address, 0);
      check("rst_perr", 32'(protocol_error), 0);
      check("rst_state", 32'(dut.state), 32'(ST_IDLE));
      reset = 1'b0;
      tick();
      #2;
      check("idle_state", 32'(dut.state), 32'(ST_IDLE));

      // ---------------- icache burst, 8 beats, fulfilled every 2nd cycle ----------------
      ic_req_valid   = 1'b1;
      ic_req_address = 32'h0000_0100;
      #2;
      check("ic_valid_lag", 32'(l2_req_valid), 0);
      tick();
      #2;
      check("ic_valid_rise", 32'(l2_req_valid), 1);
      check("ic_addr_mux", l2_req_address, 32'h0000_0100);
      check("ic_wdata_zero", l2_req_wdata, 0);
      icn = 0; dcn = 0; k = 0;
      while (icn < 8 && k < 40) begin
         l2_req_fulfilled = k[0];
         l2_req_rdata     = 32'hA5A5_0000 + 32'(k);
         #2;
         if (ic_req_fulfilled === 1'b1) begin
            icn++;
            check("ic_rdata", ic_req_rdata, 32'hA5A5_0000 + 32'(k));
            check("dc_rdata_zero", dc_req_rdata, 0);
         end
         if (dc_req_fulfilled === 1'b1) dcn++;
         tick();
         k++;
      end
      check("ic_burst_cycles", 32'(k), 16);
      ic_req_valid     = 1'b0;
      l2_req_fulfilled = 1'b0;
      #2;
      check("ic_beats", 32'(icn), 8);
      check("ic_dc_beats", 32'(dcn), 0);
      tick();
      #2;
      check("ic_back_idle", 32'(dut.state), 32'(ST_IDLE));

      // ---------------- tie right after reset ----------------
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      ic_req_valid   = 1'b1;
      ic_req_address = 32'h0000_3000;
      dc_req_valid   = 1'b1;
      dc_req_type    = LOAD;
      dc_req_address = 32'h0000_2000;
      tick();
      l2_req_fulfilled = 1'b1;
      l2_req_rdata     = 32'h1111_2222;
      #2;
      check("tie_first_ic", 32'(dut.state), 32'(ST_GRANT_IC));
      check("tie_ic_addr", l2_req_address, 32'h0000_3000);
      check("tie_ic_f", 32'(ic_req_fulfilled), 1);
      check("tie_dc_f", 32'(dc_req_fulfilled), 0);
      tick();
      ic_req_valid     = 1'b0;
      l2_req_fulfilled = 1'b0;
      tick();
      l2_req_fulfilled = 1'b1;
      l2_req_rdata     = 32'h3333_4444;
      #2;
      check("tie_no_bubble", 32'(dut.state), 32'(ST_GRANT_DC));
      check("tie_dc_addr", l2_req_address, 32'h0000_2000);
      check("tie_dc_f", 32'(dc_req_fulfilled), 1);
      check("tie_dc_rdata", dc_req_rdata, 32'h3333_4444);
      check("tie_ic_f_off", 32'(ic_req_fulfilled), 0);
      tick();
      dc_req_valid     = 1'b0;
      l2_req_fulfilled = 1'b0;
      tick();
      #2;
      check("tie_idle", 32'(dut.state), 32'(ST_IDLE));
      ic_req_valid = 1'b1;
      dc_req_valid = 1'b1;
      tick();
      #2;
      check("tie_second_ic", 32'(dut.state), 32'(ST_GRANT_IC));
      ic_req_valid = 1'b0;
      dc_req_valid = 1'b0;
      tick();
      tick();

      // ---------------- dcache STORE ----------------
      dc_req_valid   = 1'b1;
      dc_req_type    = STORE;
      dc_req_address = 32'h0000_1000;
      dc_req_wdata   = 32'hDEAD_BEEF;
      tick();
      l2_req_fulfilled = 1'b1;
      #2;
      check("st_type", 32'(l2_req_type), 32'(STORE));
      check("st_addr", l2_req_address, 32'h0000_1000);
      check("st_wdata", l2_req_wdata, 32'hDEAD_BEEF);
      check("st_dc_f", 32'(dc_req_fulfilled), 1);
      check("st_ic_f", 32'(ic_req_fulfilled), 0);
      check("st_ic_rdata", ic_req_rdata, 0);
      tick();
      dc_req_valid     = 1'b0;
      dc_req_type      = LOAD;
      l2_req_fulfilled = 1'b0;
      tick();

      // ---------------- lock limit: icache 16 beats, dcache waiting ----------------
      ic_req_valid   = 1'b1;
      ic_req_address = 32'h0000_4000;
      tick();
      dc_req_valid   = 1'b1;
      dc_req_address = 32'h0000_5000;
      icn = 0; dcn = 0;
      // Contended cycles g0..g3 saturate the counter at 4. g4 and g5 carry no
      // beat, so the grant stays. The beat in g6 triggers the rotation.
      for (int g = 0; g < 7; g++) begin
         l2_req_fulfilled = (g == 0 || g == 1 || g == 6);
         #2;
         check("lock_hold_ic", 32'(dut.state), 32'(ST_GRANT_IC));
         check("lock_ic_f", 32'(ic_req_fulfilled), 32'(g == 0 || g == 1 || g == 6));
         if (ic_req_fulfilled === 1'b1) icn++;
         tick();
      end
      for (int d = 0; d < 2; d++) begin
         l2_req_fulfilled = 1'b1;
         #2;
         check("lock_to_dc", 32'(dut.state), 32'(ST_GRANT_DC));
         check("lock_dc_addr", l2_req_address, 32'h0000_5000);
         check("lock_ic_paused", 32'(ic_req_fulfilled), 0);
         if (dc_req_fulfilled === 1'b1) dcn++;
         tick();
      end
      dc_req_valid     = 1'b0;
      l2_req_fulfilled = 1'b0;
      tick();
      #2;
      check("lock_ic_resume", 32'(dut.state), 32'(ST_GRANT_IC));
      k = 0;
      while (icn < 16 && k < 40) begin
         l2_req_fulfilled = 1'b1;
         #2;
         if (ic_req_fulfilled === 1'b1) icn++;
         tick();
         k++;
      end
      ic_req_valid     = 1'b0;
      l2_req_fulfilled = 1'b0;
      check("lock_ic_total", 32'(icn), 16);
      check("lock_resume_cycles", 32'(k), 13);
      check("lock_dc_total", 32'(dcn), 2);
      tick();

      // ---------------- fulfilled with no request outstanding ----------------
      #2;
      check("perr_clear", 32'(protocol_error), 0);
      l2_req_fulfilled = 1'b1;
      #1;
      check("perr_ic_f", 32'(ic_req_fulfilled), 0);
      check("perr_dc_f", 32'(dc_req_fulfilled), 0);
      tick();
      l2_req_fulfilled = 1'b0;
      #2;
      check("perr_set", 32'(protocol_error), 1);
      tick();
      #2;
      check("perr_sticky", 32'(protocol_error), 1);

      // ---------------- reset during the 3rd beat of a dcache burst ----------------
      dc_req_valid   = 1'b1;
      dc_req_address = 32'h0000_6000;
      tick();
      for (int b = 0; b < 2; b++) begin
         l2_req_fulfilled = 1'b1;
         #2;
         check("rb_dc_f", 32'(dc_req_fulfilled), 1);
         tick();
      end
      reset            = 1'b1;
      l2_req_fulfilled = 1'b1;
      #2;
      check("rb_no_fwd", 32'(dc_req_fulfilled), 0);
      check("rb_valid_drop", 32'(l2_req_valid), 0);
      tick();
      reset            = 1'b0;
      l2_req_fulfilled = 1'b0;
      #2;
      check("rb_state_idle", 32'(dut.state), 32'(ST_IDLE));
      check("rb_l2_valid", 32'(l2_req_valid), 0);
      check("rb_perr", 32'(protocol_error), 0);
      tick();
      #2;
      check("rb_regrant", 32'(dut.state), 32'(ST_GRANT_DC));
      dc_req_valid = 1'b0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
